// File: rtl/branch_seq_if.sv
// Fetch / register-read / execute-issue signal bundle for branch_seq.
// master = sequencer side, slave = memory, register file and execute stage.
interface branch_seq_if;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [2:0]  rf_raddr;
   logic [7:0]  rf_rdata;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  pc;
   logic        br_taken;

   modport master (
      output imem_req, imem_addr, rf_raddr, instr_out, instr_valid, pc, br_taken,
      input  imem_ack, imem_data, rf_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, rf_raddr, instr_out, instr_valid, pc, br_taken,
      output imem_ack, imem_data, rf_rdata, instr_ready
   );
endinterface

// File: rtl/branch_seq.sv
// Fetch/branch sequencer: fetches over req/ack, resolves branches locally, issues the rest over valid/ready (3-5 cycles).
// Stalls in FETCH until imem_ack and in ISSUE until instr_ready; BRANCH_SEQ_FASTJ_EN resolves J in DECODE.
module branch_seq #(
   parameter logic [7:0] RESET_PC     = 8'h00,
   parameter int          IMEM_TIMEOUT = 0
) (
   input logic         clk,
   input logic         rst,
   branch_seq_if.master bus
);
   localparam logic [4:0] OP_BNE  = 5'b10011;
   localparam logic [4:0] OP_BE   = 5'b10100;
   localparam logic [4:0] OP_BNER = 5'b10101;
   localparam logic [4:0] OP_BER  = 5'b10110;
   localparam logic [4:0] OP_J    = 5'b10111;
   localparam logic [4:0] OP_JR   = 5'b11000;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_RDA, S_RDB, S_RESOLVE, S_ISSUE
   } state_t;

   state_t      state;
   logic [7:0]  pc_r;
   logic [7:0]  npc;
   logic [15:0] ir;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        imem_req_r;
   logic [2:0]  rf_raddr_r;
   logic [15:0] instr_out_r;
   logic        instr_valid_r;
   logic        br_taken_r;

   logic [4:0]  op;
   logic        is_branch;
   logic        two_reg;
   logic        fetch_done;
   logic [7:0]  target;
   logic [7:0]  rdata;

   assign op        = ir[15:11];
   assign is_branch = (op >= OP_BNE) && (op <= OP_JR);
   assign two_reg   = (op == OP_BNER) || (op == OP_BER);
   assign rdata     = bus.rf_rdata;
   // No timeout path exists; IMEM_TIMEOUT is reserved and held at 0.
   assign fetch_done = imem_req_r && bus.imem_ack && (IMEM_TIMEOUT == 0);

   function automatic logic cond_met(input logic [4:0] opc, input logic [7:0] val);
      case (opc)
         OP_BNE, OP_BNER: cond_met = (val != 8'h00);
         OP_BE,  OP_BER:  cond_met = (val == 8'h00);
         default:         cond_met = 1'b1;
      endcase
   endfunction

   always_comb begin
      target = ir[7:0];
      case (op)
         OP_JR:           target = a;
         OP_BNER, OP_BER: target = b;
         default:         target = ir[7:0];
      endcase
   end

   // br_taken is registered on entry to RESOLVE so the pulse coincides with the redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FETCH;
         pc_r          <= RESET_PC;
         npc           <= 8'h00;
         ir            <= 16'h0000;
         a             <= 8'h00;
         b             <= 8'h00;
         imem_req_r    <= 1'b0;
         rf_raddr_r    <= 3'd0;
         instr_out_r   <= 16'h0000;
         instr_valid_r <= 1'b0;
         br_taken_r    <= 1'b0;
      end else begin
         br_taken_r <= 1'b0;
         case (state)
            S_FETCH: begin
               if (!imem_req_r) begin
                  imem_req_r <= 1'b1;
               end else if (fetch_done) begin
                  ir         <= bus.imem_data;
                  npc        <= pc_r + 8'd1;
                  imem_req_r <= 1'b0;
                  state      <= S_DECODE;
`ifdef BRANCH_SEQ_FASTJ_EN
                  br_taken_r <= (bus.imem_data[15:11] == OP_J);
`endif
               end
            end
            S_DECODE: begin
               if (!is_branch) begin
                  instr_out_r   <= ir;
                  instr_valid_r <= 1'b1;
                  state         <= S_ISSUE;
               end else if (op == OP_J) begin
`ifdef BRANCH_SEQ_FASTJ_EN
                  pc_r       <= ir[7:0];
                  imem_req_r <= 1'b1;
                  state      <= S_FETCH;
`else
                  br_taken_r <= 1'b1;
                  state      <= S_RESOLVE;
`endif
               end else begin
                  rf_raddr_r <= (op == OP_JR) ? ir[2:0] : ir[10:8];
                  state      <= S_RDA;
               end
            end
            S_RDA: begin
               a <= rdata;
               if (two_reg) begin
                  rf_raddr_r <= ir[2:0];
                  state      <= S_RDB;
               end else begin
                  br_taken_r <= cond_met(op, rdata);
                  state      <= S_RESOLVE;
               end
            end
            S_RDB: begin
               b          <= rdata;
               br_taken_r <= cond_met(op, a);
               state      <= S_RESOLVE;
            end
            S_RESOLVE: begin
               pc_r       <= br_taken_r ? target : npc;
               imem_req_r <= 1'b1;
               state      <= S_FETCH;
            end
            S_ISSUE: begin
               if (bus.instr_ready) begin
                  instr_valid_r <= 1'b0;
                  pc_r          <= npc;
                  imem_req_r    <= 1'b1;
                  state         <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   assign bus.imem_req    = imem_req_r;
   assign bus.imem_addr   = pc_r;
   assign bus.rf_raddr    = rf_raddr_r;
   assign bus.instr_out   = instr_out_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.pc          = pc_r;
   assign bus.br_taken    = br_taken_r;
endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: per-instruction vector table plus reset/stall sequences.
module tb_branch_seq;
`ifdef BRANCH_SEQ_FASTJ_EN
   localparam int JLAT = 2;
`else
   localparam int JLAT = 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_seq_if bus();
   branch_seq #(.RESET_PC(8'h00), .IMEM_TIMEOUT(0)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [15:0] mem [256];
   logic [7:0]  rf  [8];
   logic        ready      = 1'b1;
   logic        block_en   = 1'b0;
   logic        ack_force  = 1'b0;
   logic [7:0]  block_addr = 8'h00;

   assign bus.imem_ack    = (bus.imem_req && !(block_en && bus.imem_addr == block_addr)) || ack_force;
   assign bus.imem_data   = mem[bus.imem_addr];
   assign bus.rf_rdata    = rf[bus.rf_raddr];
   assign bus.instr_ready = ready;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reset, load a program with the word under test at addr (reached via J from 00), release reset.
   task automatic start(input logic [7:0] addr, input logic [15:0] word, input logic [63:0] regs);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      for (int r = 0; r < 8; r++) rf[r] = regs[r*8 +: 8];
      if (addr == 8'h00) mem[0] = word;
      else begin
         mem[0]    = {5'b10111, 3'b000, addr};
         mem[addr] = word;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_fetch(input logic [7:0] addr, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (bus.imem_req && bus.imem_ack && bus.imem_addr == addr) ok = 1'b1;
      end
   endtask

   task automatic next_fetch(input int budget, output bit ok, output logic [7:0] addr,
                             output int cycles, output int pulses, output int issued,
                             output logic [15:0] word);
      ok = 1'b0; addr = 8'h00; cycles = 0; pulses = 0; issued = 0; word = 16'h0000;
      while (!ok && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (bus.br_taken) pulses++;
         if (bus.instr_valid && bus.instr_ready) begin
            issued++;
            word = bus.instr_out;
         end
         if (bus.imem_req && bus.imem_ack) begin
            ok   = 1'b1;
            addr = bus.imem_addr;
         end
      end
   endtask

   typedef struct {
      string       name;
      logic [7:0]  addr;
      logic [15:0] word;
      logic [63:0] regs;   // {R7..R0}
      logic [7:0]  nxt;
      int          lat;
      int          pulses;
      bit          issues;
   } vec_t;

   vec_t vecs [14];

   initial begin
      bit          ok;
      logic [7:0]  na;
      int          cyc, pul, iss;
      logic [15:0] w;
      logic [15:0] seq_words [3];

      vecs[0]  = '{"nb_00",      8'h00, 16'h1234, 64'h0,                   8'h01, 3,    0, 1'b1};
      vecs[1]  = '{"bne_taken",  8'h05, 16'h9A40, 64'h00000000_00070000,   8'h40, 4,    1, 1'b0};
      vecs[2]  = '{"bne_fall",   8'h05, 16'h9A40, 64'h11111111_11001111,   8'h06, 4,    0, 1'b0};
      vecs[3]  = '{"be_taken",   8'h08, 16'hA433, 64'h11111100_11111111,   8'h33, 4,    1, 1'b0};
      vecs[4]  = '{"be_fall",    8'h08, 16'hA433, 64'h00000005_00000000,   8'h09, 4,    0, 1'b0};
      vecs[5]  = '{"ber_taken",  8'h10, 16'hB103, 64'h55555555_9C550055,   8'h9C, 5,    1, 1'b0};
      vecs[6]  = '{"ber_fall",   8'h10, 16'hB103, 64'h55555555_9C550155,   8'h11, 5,    0, 1'b0};
      vecs[7]  = '{"bner_taken", 8'h30, 16'hAD06, 64'h55770355_55555555,   8'h77, 5,    1, 1'b0};
      vecs[8]  = '{"jr",         8'h50, 16'hC007, 64'hA5000000_00000000,   8'hA5, 4,    1, 1'b0};
      vecs[9]  = '{"j_at_ff",    8'hFF, 16'hB820, 64'h0,                   8'h20, JLAT, 1, 1'b0};
      vecs[10] = '{"nb_wrap",    8'hFF, 16'h0F0F, 64'h0,                   8'h00, 3,    0, 1'b1};
      vecs[11] = '{"j_self",     8'h60, 16'hB860, 64'h0,                   8'h60, JLAT, 1, 1'b0};
      vecs[12] = '{"nb_op19",    8'h70, 16'hC800, 64'h0,                   8'h71, 3,    0, 1'b1};
      vecs[13] = '{"nb_op12",    8'h72, 16'h9000, 64'h0,                   8'h73, 3,    0, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      for (int r = 0; r < 8; r++) rf[r] = 8'h00;

      // Reset values, then three sequential non-branch words.
      repeat (2) @(negedge clk);
      check("rst_pc",          int'(bus.pc),          0);
      check("rst_imem_req",    int'(bus.imem_req),    0);
      check("rst_instr_valid", int'(bus.instr_valid), 0);
      check("rst_br_taken",    int'(bus.br_taken),    0);
      check("rst_rf_raddr",    int'(bus.rf_raddr),    0);
      check("rst_instr_out",   int'(bus.instr_out),   0);
      seq_words[0] = 16'h1111; seq_words[1] = 16'h2222; seq_words[2] = 16'h3333;
      for (int k = 0; k < 3; k++) mem[k] = seq_words[k];
      rst = 1'b0;
      #1 check("req_low_at_release", int'(bus.imem_req), 0);
      @(negedge clk);
      check("req_one_cycle_after_rst", int'(bus.imem_req), 1);
      check("first_fetch_addr",        int'(bus.imem_addr), 0);
      for (int k = 0; k < 3; k++) begin
         next_fetch(20, ok, na, cyc, pul, iss, w);
         check("seq_fetch_seen", int'(ok), 1);
         check("seq_issue_cnt",  iss, 1);
         check("seq_issue_word", int'(w), int'(seq_words[k]));
         check("seq_pc",         int'(bus.pc), k + 1);
      end

      // Table: one instruction each, measure fetch-to-fetch behaviour.
      for (int v = 0; v < 14; v++) begin
         start(vecs[v].addr, vecs[v].word, vecs[v].regs);
         wait_fetch(vecs[v].addr, 20, ok);
         check({vecs[v].name, "_fetch_seen"}, int'(ok), 1);
         next_fetch(20, ok, na, cyc, pul, iss, w);
         check({vecs[v].name, "_next_seen"}, int'(ok), 1);
         check({vecs[v].name, "_next_addr"}, int'(na), int'(vecs[v].nxt));
         check({vecs[v].name, "_latency"},   cyc, vecs[v].lat);
         check({vecs[v].name, "_br_pulses"}, pul, vecs[v].pulses);
         check({vecs[v].name, "_issued"},    iss, vecs[v].issues ? 1 : 0);
         if (vecs[v].issues) check({vecs[v].name, "_issue_word"}, int'(w), int'(vecs[v].word));
      end

      // ISSUE stall with instr_ready low.
      ready = 1'b0;
      start(8'h00, 16'h1234, 64'h0);
      wait_fetch(8'h00, 10, ok);
      check("stall_fetch_seen", int'(ok), 1);
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (bus.instr_valid) ok = 1'b1;
      end
      check("stall_valid_seen", int'(ok), 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("stall_instr_out", int'(bus.instr_out),   16'h1234);
         check("stall_valid",     int'(bus.instr_valid), 1);
         check("stall_pc",        int'(bus.pc),          0);
         check("stall_no_fetch",  int'(bus.imem_req),    0);
      end
      ready = 1'b1;
      @(negedge clk);
      check("unstall_pc",    int'(bus.pc),          1);
      check("unstall_req",   int'(bus.imem_req),    1);
      check("unstall_valid", int'(bus.instr_valid), 0);

      // Reset while in RDB of a BER at 0x10.
      start(8'h10, 16'hB103, 64'h55555555_9C550055);
      wait_fetch(8'h10, 20, ok);
      check("rdb_fetch_seen", int'(ok), 1);
      repeat (3) @(negedge clk);
      check("rdb_raddr_before", int'(bus.rf_raddr), 3);
      rst = 1'b1;
      #1;
      check("rdb_rst_pc",       int'(bus.pc),          0);
      check("rdb_rst_raddr",    int'(bus.rf_raddr),    0);
      check("rdb_rst_req",      int'(bus.imem_req),    0);
      check("rdb_rst_br_taken", int'(bus.br_taken),    0);
      check("rdb_rst_valid",    int'(bus.instr_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_fetch(8'h00, 4, ok);
      check("rdb_refetch_00", int'(ok), 1);

      // Reset during a stalled FETCH, with ack asserted while in reset.
      block_en   = 1'b1;
      block_addr = 8'h44;
      start(8'h44, 16'h1234, 64'h0);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (bus.imem_req && bus.imem_addr == 8'h44) ok = 1'b1;
      end
      check("fetch_stall_seen", int'(ok), 1);
      repeat (2) @(negedge clk);
      check("fetch_stall_pc",  int'(bus.pc),       8'h44);
      check("fetch_stall_req", int'(bus.imem_req), 1);
      rst       = 1'b1;
      ack_force = 1'b1;
      #1;
      check("fetch_rst_pc",  int'(bus.pc),       0);
      check("fetch_rst_req", int'(bus.imem_req), 0);
      repeat (2) @(negedge clk);
      check("ack_in_rst_pc",    int'(bus.pc),          0);
      check("ack_in_rst_req",   int'(bus.imem_req),    0);
      check("ack_in_rst_valid", int'(bus.instr_valid), 0);
      ack_force = 1'b0;
      block_en  = 1'b0;
      rst       = 1'b0;
      wait_fetch(8'h00, 4, ok);
      check("fetch_refetch_00", int'(ok), 1);
      next_fetch(10, ok, na, cyc, pul, iss, w);
      check("fetch_refetch_next", int'(na), 8'h44);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
